ltc_bitslip_ctrl: RTL

Word-alignment sequencer for the LTC ADC LVDS capture path on SP605. It watches the deserialized 8-bit frame-clock word and issues single-cycle bitslip pulses to the ISERDES until the word matches the expected frame pattern, then supervises lock. It sits between the ISERDES/deserializer outputs and the CSR bank in the sys_clk domain.

---
 rtl/ltc_bitslip_ctrl_if.sv | 38 +++
 rtl/ltc_bitslip_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ltc_bitslip_ctrl_if.sv
// ltc_bitslip_ctrl_if -- control, deserialized-word and status bundle of ltc_bitslip_ctrl.
// master: the side that feeds words and watches status. slave: the sequencer itself.
// Build macro LTC_TP_CHECK_EN adds the test-pattern status signals tp_ok and tp_err_count.

interface ltc_bitslip_ctrl_if #(
  parameter int SLIP_W = 5
);
  logic              start;
  logic              word_valid;
  logic [7:0]        frame_word;
  logic [7:0]        data_a;
  logic [7:0]        data_b;
  logic              bitslip;
  logic              busy;
  logic              aligned;
  logic              fail;
  logic [SLIP_W-1:0] slip_count;
`ifdef LTC_TP_CHECK_EN
  logic              tp_ok;
  logic [15:0]       tp_err_count;
`endif

  modport master (
    output start, word_valid, frame_word, data_a, data_b,
    input  bitslip, busy, aligned, fail, slip_count
`ifdef LTC_TP_CHECK_EN
    , input tp_ok, tp_err_count
`endif
  );

  modport slave (
    input  start, word_valid, frame_word, data_a, data_b,
    output bitslip, busy, aligned, fail, slip_count
`ifdef LTC_TP_CHECK_EN
    , output tp_ok, tp_err_count
`endif
  );
endinterface

// File: rtl/ltc_bitslip_ctrl.sv
// ltc_bitslip_ctrl -- word-alignment sequencer for the LTC ADC LVDS capture path (sys_clk domain).
// Slips the ISERDES one bit at a time until the frame lane shows FRAME_PATTERN for
// MATCH_COUNT consecutive words, then supervises lock and restarts on loss.
// Build macro LTC_TP_CHECK_EN adds ADC test-pattern checking (tp_ok, tp_err_count).

module ltc_bitslip_ctrl #(
  parameter logic [7:0]  FRAME_PATTERN  = 8'hF0,
  parameter int          SETTLE_CYCLES  = 16,
  parameter int          MATCH_COUNT    = 8,
  parameter int          MAX_SLIPS      = 16,
  parameter int          LOSS_THRESHOLD = 4
`ifdef LTC_TP_CHECK_EN
  ,
  parameter logic [15:0] TP             = 16'h3DDA
`endif
) (
  input logic               sys_clk,
  input logic               sys_rst,
  ltc_bitslip_ctrl_if.slave bus
);

  localparam int SLIP_W   = $clog2(MAX_SLIPS + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int MATCH_W  = $clog2(MATCH_COUNT + 1);
  localparam int MISS_W   = $clog2(LOSS_THRESHOLD + 1);

  localparam logic [SLIP_W-1:0]   SLIP_MAX    = SLIP_W'(MAX_SLIPS);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
  localparam logic [MISS_W-1:0]   MISS_LAST   = MISS_W'(LOSS_THRESHOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_SLIP,
    S_ALIGNED,
    S_FAIL
  } state_t;

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [MATCH_W-1:0]  match_cnt;
  logic [MISS_W-1:0]   miss_cnt;
  logic                frame_match;
  logic                restart;

  // Frame comparison and the two ways a fresh attempt begins: a start request when
  // not busy, or the last tolerated miss while aligned (no bitslip on that path).
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    frame_match = (bus.frame_word == FRAME_PATTERN);
    restart     = 1'b0;
    if (bus.start && (state == S_IDLE || state == S_ALIGNED || state == S_FAIL))
      restart = 1'b1;
    else if (state == S_ALIGNED && bus.word_valid && !frame_match && miss_cnt == MISS_LAST)
      restart = 1'b1;
  end

  // Sequencer: state, counters and every registered status output.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state          <= S_IDLE;
      settle_cnt     <= '0;
      match_cnt      <= '0;
      miss_cnt       <= '0;
      bus.bitslip    <= 1'b0;
      bus.busy       <= 1'b0;
      bus.aligned    <= 1'b0;
      bus.fail       <= 1'b0;
      bus.slip_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; the low default
      // here is what limits every bitslip pulse to a single cycle.
      bus.bitslip <= 1'b0;
      if (restart) begin
        state          <= S_SETTLE;
        settle_cnt     <= '0;
        match_cnt      <= '0;
        miss_cnt       <= '0;
        bus.busy       <= 1'b1;
        bus.aligned    <= 1'b0;
        bus.fail       <= 1'b0;
        bus.slip_count <= '0;
      end else begin
        case (state)
          S_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state     <= S_CHECK;
              match_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          S_CHECK: begin
            if (bus.word_valid) begin
              if (frame_match) begin
                match_cnt <= match_cnt + 1'b1;
                if (match_cnt == MATCH_LAST) begin
                  state       <= S_ALIGNED;
                  miss_cnt    <= '0;
                  bus.busy    <= 1'b0;
                  bus.aligned <= 1'b1;
                end
              end else if (bus.slip_count == SLIP_MAX) begin
                state    <= S_FAIL;
                bus.busy <= 1'b0;
                bus.fail <= 1'b1;
              end else begin
                state       <= S_SLIP;
                bus.bitslip <= 1'b1;
              end
            end
          end
          S_SLIP: begin
            state          <= S_SETTLE;
            settle_cnt     <= '0;
            bus.slip_count <= bus.slip_count + 1'b1;
          end
          S_ALIGNED: begin
            if (bus.word_valid)
              miss_cnt <= frame_match ? '0 : miss_cnt + 1'b1;
          end
          S_IDLE, S_FAIL: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef LTC_TP_CHECK_EN
  logic [15:0] tp_sample;
  logic        enter_settle;

  // Rebuild the 16-bit ADC sample by interleaving the lanes, OUT_a bit above OUT_b bit.
  always_comb begin
    tp_sample = '0;
    for (int i = 0; i < 8; i++) begin
      tp_sample[2*i+1] = bus.data_a[i];
      tp_sample[2*i]   = bus.data_b[i];
    end
  end

  assign enter_settle = restart || (state == S_SLIP);

  // Test-pattern supervision on aligned words; cleared whenever a new settle begins.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bus.tp_ok        <= 1'b0;
      bus.tp_err_count <= '0;
    end else if (enter_settle) begin
      bus.tp_ok        <= 1'b0;
      bus.tp_err_count <= '0;
    end else if (state == S_ALIGNED && bus.word_valid) begin
      bus.tp_ok <= (tp_sample == TP);
      if (tp_sample != TP && bus.tp_err_count != 16'hFFFF)
        bus.tp_err_count <= bus.tp_err_count + 16'd1;
    end
  end
`else
  // The data lanes only feed the test-pattern checker.
  logic unused_lanes;
  assign unused_lanes = ^{bus.data_a, bus.data_b};
`endif

endmodule
